// File: rtl/if_fetch_unit_pkg.sv
// Shared mips_16 fetch definitions: default widths, reset PC and the
// redirect-cause encoding used by the fetch unit's target mux.
package mips_16_defs;

  localparam int unsigned PC_WIDTH_DEF = 16;
  localparam int unsigned RESET_PC_DEF = 0;

  typedef enum logic [1:0] {
    REDIR_NONE   = 2'd0,
    REDIR_BRANCH = 2'd1,
    REDIR_JUMP   = 2'd2
  } redirect_cause_e;

  // Branch beats jump when both fire: the branch belongs to the older instruction.
  function automatic redirect_cause_e redirect_cause(input logic branch, input logic jump);
    if (branch)    return REDIR_BRANCH;
    else if (jump) return REDIR_JUMP;
    else           return REDIR_NONE;
  endfunction

endpackage

// File: rtl/if_fetch_unit_pc_queue.sv
// if_pc_queue: synchronous FIFO of fetched PCs with flush; power-of-2 depth,
// pointers wrap naturally. dout_o reads 0 while the queue is empty.
module if_pc_queue #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i && !rst_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC register with branch/jump redirect feeding a PC FIFO drained
// by decode. Optional perf counters enabled by macro IF_FETCH_PERF_CNT_EN.
module if_fetch_unit
  import mips_16_defs::*;
#(
  parameter int unsigned         PC_WIDTH     = PC_WIDTH_DEF,
  parameter int unsigned         OFFSET_WIDTH = 6,
  parameter int unsigned         QUEUE_DEPTH  = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC     = PC_WIDTH'(RESET_PC_DEF)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          fetch_en,
  input  logic                          branch_taken,
  input  logic [PC_WIDTH-1:0]           branch_base_pc,
  input  logic [OFFSET_WIDTH-1:0]       branch_offset,
  input  logic                          jump_taken,
  input  logic [PC_WIDTH-1:0]           jump_target,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [PC_WIDTH-1:0]           out_pc,
  output logic [PC_WIDTH-1:0]           fetch_pc,
  output logic [$clog2(QUEUE_DEPTH):0]  queue_count
`ifdef IF_FETCH_PERF_CNT_EN
  ,
  output logic [31:0]                   redirect_cnt,
  output logic [31:0]                   stall_cnt
`endif
);

  localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

  logic                  redirect, pop, push, q_pop;
  redirect_cause_e       cause;
  logic [PC_WIDTH-1:0]   target;
  logic [PC_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;

  assign redirect = branch_taken | jump_taken;
  assign cause    = redirect_cause(branch_taken, jump_taken);
  assign pop      = out_valid & out_ready;
  assign push     = fetch_en & ((queue_count < DEPTH_C) | pop) & ~redirect;
  // A redirect discards any handshake offered in the same cycle.
  assign q_pop    = pop & ~redirect;

  always_comb begin
    target = fetch_pc_q;
    case (cause)
      REDIR_BRANCH: target = branch_base_pc + PC_WIDTH'($signed(branch_offset));
      REDIR_JUMP:   target = jump_target;
      default:      target = fetch_pc_q;
    endcase
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect)  fetch_pc_d = target;
    else if (push) fetch_pc_d = fetch_pc_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) fetch_pc_q <= RESET_PC;
    else     fetch_pc_q <= fetch_pc_d;
  end

  if_pc_queue #(
    .WIDTH (PC_WIDTH),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push),
    .pop_i   (q_pop),
    .flush_i (redirect),
    .din_i   (fetch_pc_q),
    .dout_o  (out_pc),
    .count_o (queue_count)
  );

  assign out_valid = (queue_count != '0);
  assign fetch_pc  = fetch_pc_q;

`ifdef IF_FETCH_PERF_CNT_EN
  logic [31:0] redirect_cnt_q, stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      if (redirect && redirect_cnt_q != '1)
        redirect_cnt_q <= redirect_cnt_q + 1'b1;
      if (fetch_en && !redirect && !push && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign redirect_cnt = redirect_cnt_q;
  assign stall_cnt    = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: expected head PCs are queued with each
// stimulus step and checked by a negedge monitor on every accepted handshake.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, fetch_en, branch_taken, jump_taken, out_ready;
  logic [15:0] branch_base_pc, jump_target;
  logic [5:0]  branch_offset;
  logic        out_valid;
  logic [15:0] out_pc, fetch_pc;
  logic [2:0]  queue_count;
`ifdef IF_FETCH_PERF_CNT_EN
  logic [31:0] redirect_cnt, stall_cnt;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  if_fetch_unit #(
    .PC_WIDTH     (16),
    .OFFSET_WIDTH (6),
    .QUEUE_DEPTH  (4),
    .RESET_PC     (16'h0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .branch_taken   (branch_taken),
    .branch_base_pc (branch_base_pc),
    .branch_offset  (branch_offset),
    .jump_taken     (jump_taken),
    .jump_target    (jump_target),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .fetch_pc       (fetch_pc),
    .queue_count    (queue_count)
`ifdef IF_FETCH_PERF_CNT_EN
    ,
    .redirect_cnt   (redirect_cnt),
    .stall_cnt      (stall_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic cyc(input int unsigned n = 1);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: a handshake seen at negedge is consumed at the next posedge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready && !branch_taken && !jump_taken) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", {16'h0, out_pc}, 32'hDEAD_BEEF);
      end else begin
        chk("out_pc", {16'h0, out_pc}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    rst = 1'b1; fetch_en = 1'b0; branch_taken = 1'b0; jump_taken = 1'b0;
    out_ready = 1'b0; branch_base_pc = '0; branch_offset = '0; jump_target = '0;
    cyc(2);
    rst = 1'b0;
    chk("rst_fetch_pc", {16'h0, fetch_pc}, 32'h0);
    chk("rst_count", {29'h0, queue_count}, 32'd0);
    chk("rst_valid", {31'h0, out_valid}, 32'd0);
    chk("rst_out_pc", {16'h0, out_pc}, 32'h0);

    // Streaming: head PCs 0..4 drained back-to-back.
    fetch_en = 1'b1; out_ready = 1'b1;
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0001); exp_q.push_back(16'h0002);
    exp_q.push_back(16'h0003); exp_q.push_back(16'h0004);
    cyc(5);
    chk("stream_fetch_pc", {16'h0, fetch_pc}, 32'h5);
    fetch_en = 1'b0;
    cyc(1);
    chk("stream_drained", {29'h0, queue_count}, 32'd0);

    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    exp_q.delete();

    // Back-pressure: queue fills to 4, fetch_pc stalls at 4.
    out_ready = 1'b0; fetch_en = 1'b1;
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0002); exp_q.push_back(16'h0003);
    cyc(6);
    chk("full_count", {29'h0, queue_count}, 32'd4);
    chk("full_fetch_pc", {16'h0, fetch_pc}, 32'h4);
    chk("full_valid", {31'h0, out_valid}, 32'd1);
    chk("full_head", {16'h0, out_pc}, 32'h0);
    out_ready = 1'b1;
    exp_q.push_back(16'h0004);
    cyc(1);
    chk("full_pushpop_fetch_pc", {16'h0, fetch_pc}, 32'h5);
    chk("full_pushpop_count", {29'h0, queue_count}, 32'd4);
    fetch_en = 1'b0;
    cyc(5);
    chk("drain_count", {29'h0, queue_count}, 32'd0);

    // Branch with negative offset flushes a partly filled queue.
    out_ready = 1'b0; fetch_en = 1'b1;
    cyc(2);
    chk("prebranch_count", {29'h0, queue_count}, 32'd2);
    branch_taken = 1'b1; branch_base_pc = 16'h0010; branch_offset = 6'b111110;
    out_ready = 1'b1;
    cyc(1);
    branch_taken = 1'b0;
    chk("branch_valid", {31'h0, out_valid}, 32'd0);
    chk("branch_count", {29'h0, queue_count}, 32'd0);
    chk("branch_fetch_pc", {16'h0, fetch_pc}, 32'h000E);
    exp_q.push_back(16'h000E);
    cyc(1);
    fetch_en = 1'b0;
    cyc(1);

    // Branch and jump together: branch wins.
    branch_taken = 1'b1; jump_taken = 1'b1;
    jump_target = 16'h0100; branch_base_pc = 16'h0020; branch_offset = 6'd3;
    cyc(1);
    branch_taken = 1'b0; jump_taken = 1'b0;
    chk("both_fetch_pc", {16'h0, fetch_pc}, 32'h0023);

    // Jump near the top of the PC space, then wrap.
    jump_taken = 1'b1; jump_target = 16'hFFFE;
    cyc(1);
    jump_taken = 1'b0;
    chk("jump_fetch_pc", {16'h0, fetch_pc}, 32'hFFFE);
    fetch_en = 1'b1; out_ready = 1'b1;
    exp_q.push_back(16'hFFFE); exp_q.push_back(16'hFFFF); exp_q.push_back(16'h0000);
    cyc(3);
    fetch_en = 1'b0;
    cyc(1);
    chk("wrap_fetch_pc", {16'h0, fetch_pc}, 32'h0001);
    chk("wrap_count", {29'h0, queue_count}, 32'd0);
`ifdef IF_FETCH_PERF_CNT_EN
    chk("redirect_cnt", redirect_cnt, 32'd3);
`endif

    // Reset beats a full queue plus a simultaneous redirect.
    out_ready = 1'b0; fetch_en = 1'b1;
    cyc(5);
    chk("prerst_count", {29'h0, queue_count}, 32'd4);
    rst = 1'b1; branch_taken = 1'b1; jump_taken = 1'b1; jump_target = 16'h1234;
    cyc(1);
    chk("rst2_count", {29'h0, queue_count}, 32'd0);
    chk("rst2_valid", {31'h0, out_valid}, 32'd0);
    chk("rst2_fetch_pc", {16'h0, fetch_pc}, 32'h0);
`ifdef IF_FETCH_PERF_CNT_EN
    chk("rst2_redirect_cnt", redirect_cnt, 32'd0);
    chk("rst2_stall_cnt", stall_cnt, 32'd0);
`endif
    rst = 1'b0; branch_taken = 1'b0; jump_taken = 1'b0; fetch_en = 1'b0;
    cyc(2);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Parametrised next-generation instruction-fetch front end for the mips_16 pipeline.
- Holds the program counter, which can be redirected by a PC-relative branch or an absolute jump.
- Buffers fetched PCs in a small FIFO that decode drains through a valid/ready handshake.
- Replaces the single-register PC stage.
- Adds back-pressure, flush on redirect, configurable widths and configurable depth.

Parameters:
- PC_WIDTH, 16, width of every PC value and of PC arithmetic.
- OFFSET_WIDTH, 6, width of the signed branch offset immediate.
- QUEUE_DEPTH, 4, fetch queue entries; power of 2, minimum 2.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_en  in  1  allows a fetch (push) this cycle.
- branch_taken  in  1  PC-relative redirect request.
- branch_base_pc  in  PC_WIDTH  PC the branch offset is added to.
- branch_offset  in  OFFSET_WIDTH  signed two's-complement offset.
- jump_taken  in  1  absolute redirect request.
- jump_target  in  PC_WIDTH  absolute jump PC.
- out_valid  out  1  queue head holds a valid PC.
- out_ready  in  1  decode accepts the head entry.
- out_pc  out  PC_WIDTH  PC at queue head.
- fetch_pc  out  PC_WIDTH  next PC to be fetched.
- queue_count  out  $clog2(QUEUE_DEPTH)+1  current occupancy.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset values: fetch_pc = RESET_PC; queue empty; queue_count = 0; out_valid = 0; out_pc = 0.
- Reset has priority over every other input, including mid-redirect and a full queue.
- pop = out_valid & out_ready.
- push = fetch_en & (queue_count < QUEUE_DEPTH | pop) & ~redirect.
- On push:
  - fetch_pc is written into the tail entry.
  - fetch_pc <= fetch_pc + 1, wrapping modulo 2^PC_WIDTH (0xFFFF -> 0x0000 at default width).
- Latency: a pushed PC appears on out_pc / out_valid on the cycle after the push edge, if it is at the head.
- Push and pop in the same cycle:
  - count is unchanged.
  - Allowed even when the queue is full.
- Pop from an empty queue is impossible, because out_valid = 0.
- out_pc is don't-care when out_valid = 0; drive the head entry or 0.
- redirect = branch_taken | jump_taken.
- On redirect:
  - Queue is flushed; count <= 0; read and write pointers are reset.
  - No push and no pop happen that cycle; any pending out_ready handshake is discarded.
  - fetch_pc <= target.
  - out_valid is 0 on the next cycle.
  - The first post-redirect PC is visible two cycles after the redirect edge, if fetch_en = 1.
- Branch target = branch_base_pc + sign_extend(branch_offset, PC_WIDTH), truncated to PC_WIDTH.
- branch_taken and jump_taken asserted together: the branch wins (older instruction); jump_target is ignored.
- fetch_en = 0:
  - fetch_pc holds.
  - Pops still proceed.
  - A redirect still loads fetch_pc.
- A full queue with no pop stalls fetch_pc; the head entry holds stable while out_ready = 0.

Optional Feature:
- Macro: IF_FETCH_PERF_CNT_EN.
- When defined, adds two outputs:
  - redirect_cnt [31:0]: increments on each redirect cycle.
  - stall_cnt [31:0]: increments on cycles with fetch_en & ~redirect & ~push.
  - Both counters saturate at 0xFFFFFFFF and clear on rst.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package mips_16_defs: PC_WIDTH default, RESET_PC default, redirect-cause encoding (NONE, BRANCH, JUMP) used by the target mux.
- Sub-module: if_pc_queue.
  - Synchronous FIFO, parametrised by width and depth.
  - Ports: push, pop, flush, din, dout, count.
  - The PC/redirect logic stays in the top-level module.

Test Plan:
- Reset then fetch_en = 1, out_ready = 1 for 5 cycles -> out_pc = 0, 1, 2, 3 on consecutive cycles starting 1 cycle after the first push; out_valid stays high.
- out_ready = 0, fetch_en = 1, QUEUE_DEPTH = 4 -> queue_count reaches 4 and fetch_pc stalls at 4.
  - Then raise out_ready -> out_pc = 0 and fetch_pc = 5 next cycle.
- branch_taken with branch_base_pc = 0x0010, branch_offset = 6'b111110 (-2) -> queue flushed, out_valid = 0 next cycle, fetch_pc = 0x000E, next out_pc = 0x000E.
- branch_taken and jump_taken together, jump_target = 0x0100, base = 0x0020, offset = +3 -> fetch_pc = 0x0023.
- Set fetch_pc to 0xFFFE via jump, then fetch 3 PCs -> out_pc sequence 0xFFFE, 0xFFFF, 0x0000.
- rst asserted while the queue is full and a redirect is pending -> next cycle queue_count = 0, out_valid = 0, fetch_pc = RESET_PC.
  - With IF_FETCH_PERF_CNT_EN defined, both counters also read 0.
